// File: rtl/seq_shift_add_multiplier_if.sv
// rtl/seq_shift_add_multiplier_if.sv - start/busy/done handshake and operand/result bus of the multiplier
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   multiplicand_in;
    logic [WIDTH-1:0]   multiplier_in;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, signed_mode, multiplicand_in, multiplier_in,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, multiplicand_in, multiplier_in,
        output busy, done, product
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - sequential shift-add multiplier, one partial product per cycle
module seq_shift_add_multiplier #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    seq_shift_add_multiplier_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH:0]   work_q, work_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               sgn;
    logic [WIDTH-1:0]   mcand_mag, mplier_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        sgn        = bus.signed_mode & SIGNED_EN;
        // Magnitude of the most negative value wraps to itself, which is correct as unsigned.
        mcand_mag  = (sgn && bus.multiplicand_in[WIDTH-1]) ? -bus.multiplicand_in : bus.multiplicand_in;
        mplier_mag = (sgn && bus.multiplier_in[WIDTH-1])   ? -bus.multiplier_in   : bus.multiplier_in;
        sum        = work_q[2*WIDTH:WIDTH] + (work_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        mag        = work_q[2*WIDTH-1:0];

        state_d   = state_q;
        mcand_d   = mcand_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d = mcand_mag;
                    work_d  = {{(WIDTH+1){1'b0}}, mplier_mag};
                    cnt_d   = '0;
                    neg_d   = sgn & (bus.multiplicand_in[WIDTH-1] ^ bus.multiplier_in[WIDTH-1]);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = S_FIX;
                end else begin
                    work_d = {1'b0, sum, work_q[WIDTH-1:1]};
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                // The visible product changes only here, so it holds the old result during RUN.
                product_d = neg_q ? -mag : mag;
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q == S_RUN) || (state_q == S_FIX);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - self-checking bench for the shift-add multiplier
module tb_seq_shift_add_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seq_shift_add_multiplier_if #(.WIDTH(32)) bus32 ();
    seq_shift_add_multiplier_if #(.WIDTH(8))  bus8 ();

    seq_shift_add_multiplier #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    seq_shift_add_multiplier #(.WIDTH(8),  .SIGNED_EN(1'b0)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int checks = 0;
    int errors = 0;

    int          m_cnt  [2] = '{0, 0};
    bit          m_done [2] = '{1'b0, 1'b0};
    logic [63:0] m_prod [2] = '{64'd0, 64'd0};
    logic [63:0] m_pend [2] = '{64'd0, 64'd0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact product from plain integer arithmetic, truncated to 2*w bits.
    function automatic logic [63:0] exp_prod(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] r, mask;
        if (sgn) begin
            sa = longint'(a);
            sb = longint'(b);
            if (a[w-1]) sa = sa - (64'sd1 <<< w);
            if (b[w-1]) sb = sb - (64'sd1 <<< w);
            r = 64'(sa * sb);
        end else begin
            r = {32'd0, a} * {32'd0, b};
        end
        mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        return r & mask;
    endfunction

    // Timeline model: an accepted start keeps the block busy for w+2 cycles, then one done cycle.
    task automatic model_step(input int i, input bit st, input bit sgn, input logic [31:0] a, input logic [31:0] b, input int w);
        if (m_done[i]) begin
            m_done[i] = 1'b0;
        end else if (m_cnt[i] > 0) begin
            m_cnt[i] = m_cnt[i] - 1;
            if (m_cnt[i] == 0) begin
                m_done[i] = 1'b1;
                m_prod[i] = m_pend[i];
            end
        end else if (st) begin
            m_pend[i] = exp_prod(w, sgn, a, b);
            m_cnt[i]  = w + 2;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i]  = 0;
                m_done[i] = 1'b0;
                m_prod[i] = 64'd0;
                m_pend[i] = 64'd0;
            end
        end else begin
            model_step(0, bus32.start, bus32.signed_mode, bus32.multiplicand_in, bus32.multiplier_in, 32);
            model_step(1, bus8.start, 1'b0, {24'd0, bus8.multiplicand_in}, {24'd0, bus8.multiplier_in}, 8);
        end
    end

    always @(negedge clk) begin
        check("busy32", {63'd0, bus32.busy}, {63'd0, m_cnt[0] > 0});
        check("done32", {63'd0, bus32.done}, {63'd0, m_done[0]});
        check("product32", bus32.product, m_prod[0]);
        check("busy8", {63'd0, bus8.busy}, {63'd0, m_cnt[1] > 0});
        check("done8", {63'd0, bus8.done}, {63'd0, m_done[1]});
        check("product8", {48'd0, bus8.product}, m_prod[1]);
    end

    task automatic run_op(input bit use8, input logic [31:0] a, input logic [31:0] b, input bit sm,
                          input logic [63:0] exp, input int exp_lat, input string name);
        int          lat;
        bit          seen;
        logic [63:0] prod;
        @(negedge clk);
        if (use8) begin
            bus8.multiplicand_in = a[7:0];
            bus8.multiplier_in   = b[7:0];
            bus8.signed_mode     = sm;
            bus8.start           = 1'b1;
        end else begin
            bus32.multiplicand_in = a;
            bus32.multiplier_in   = b;
            bus32.signed_mode     = sm;
            bus32.start           = 1'b1;
        end
        @(negedge clk);
        bus8.start  = 1'b0;
        bus32.start = 1'b0;
        lat  = 0;
        seen = 1'b0;
        prod = 64'd0;
        for (int k = 0; k < 200; k++) begin
            if (use8 ? bus8.done : bus32.done) begin
                seen = 1'b1;
                prod = use8 ? {48'd0, bus8.product} : bus32.product;
                break;
            end
            if (use8 ? bus8.busy : bus32.busy) lat++;
            @(negedge clk);
        end
        check({name, "_done_seen"}, {63'd0, seen}, 64'd1);
        check({name, "_product"}, prod, exp);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        @(negedge clk);
    endtask

    initial begin
        bit got_first;
        bus32.start = 1'b0; bus32.signed_mode = 1'b0; bus32.multiplicand_in = '0; bus32.multiplier_in = '0;
        bus8.start  = 1'b0; bus8.signed_mode  = 1'b0; bus8.multiplicand_in  = '0; bus8.multiplier_in  = '0;

        check("pin_unsigned", exp_prod(32, 1'b0, 32'd50, 32'd9832), 64'h0000_0000_0007_8050);
        check("pin_signed", exp_prod(32, 1'b1, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
        check("pin_minmin", exp_prod(32, 1'b1, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
        check("pin_w8", exp_prod(8, 1'b0, 32'hFF, 32'h80), 64'h7F80);

        #1 rst = 1'b0;
        #2;
        check("reset_busy", {63'd0, bus32.busy}, 64'd0);
        check("reset_done", {63'd0, bus32.done}, 64'd0);
        check("reset_product", bus32.product, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op(1'b0, 32'd50, 32'd9832, 1'b0, 64'h0000_0000_0007_8050, 34, "u_basic");
        repeat (3) @(negedge clk);
        check("hold_after", bus32.product, 64'h0000_0000_0007_8050);
        run_op(1'b0, 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 34, "s_neg3x7");
        run_op(1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB, 34, "u_neg3x7");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 34, "u_max");
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 34, "s_minmin");
        run_op(1'b0, 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 34, "s_minx1");
        run_op(1'b0, 32'd0, 32'hFFFF_FFFF, 1'b1, 64'd0, 34, "s_zero");

        // start held high with operands changing every cycle
        @(negedge clk);
        bus32.multiplicand_in = 32'd6;
        bus32.multiplier_in   = 32'd7;
        bus32.signed_mode     = 1'b0;
        bus32.start           = 1'b1;
        got_first = 1'b0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (bus32.done && !got_first) begin
                got_first = 1'b1;
                check("abuse_first", bus32.product, 64'd42);
            end
            bus32.multiplicand_in = $urandom;
            bus32.multiplier_in   = $urandom;
            bus32.signed_mode     = 1'($urandom_range(0, 1));
        end
        bus32.start = 1'b0;
        check("abuse_first_seen", {63'd0, got_first}, 64'd1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus32.busy && !bus32.done) break;
        end
        check("abuse_settled", {62'd0, bus32.busy, bus32.done}, 64'd0);

        // asynchronous reset during iteration 10
        @(negedge clk);
        bus32.multiplicand_in = 32'd50;
        bus32.multiplier_in   = 32'd9832;
        bus32.signed_mode     = 1'b0;
        bus32.start           = 1'b1;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_busy", {63'd0, bus32.busy}, 64'd0);
        check("midreset_done", {63'd0, bus32.done}, 64'd0);
        check("midreset_product", bus32.product, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_op(1'b0, 32'd50, 32'd9832, 1'b0, 64'h0000_0000_0007_8050, 34, "after_reset");

        run_op(1'b1, 32'hFF, 32'h80, 1'b1, 64'h7F80, 10, "w8_unsigned_forced");
        run_op(1'b1, 32'h03, 32'hFD, 1'b1, 64'h02F7, 10, "w8_3x253");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
Parametrised sequential shift-add multiplier. It generalises the fixed 32-bit multiplicand register into a full clocked datapath: multiplicand register, multiplier/product register, iteration counter and control FSM. Width is configurable and signed/unsigned mode is selectable per operation. It sits in the ALU beside the adder/shifter, and the ALU control drives it through a start/busy/done handshake.

Parameters:
WIDTH, 32, operand width in bits (>=2); product is 2*WIDTH bits.
SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, always unsigned.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
signed_mode  input  1  1 = two's-complement operands (sampled with start).
multiplicand_in  input  WIDTH  multiplicand operand (sampled with start).
multiplier_in  input  WIDTH  multiplier operand (sampled with start).
busy  output  1  high in RUN and FIX states.
done  output  1  one-cycle pulse when product is valid.
product  output  2*WIDTH  result; holds until next accepted start.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0; done=0; product=0; internal registers and counter cleared. Reset mid-operation aborts with no done pulse; after release the block is in IDLE.
- States: IDLE, RUN, FIX, DONE.
- IDLE: start=1 at a clock edge loads the operands.
  - Effective signed mode: sgn = signed_mode & SIGNED_EN.
  - If sgn=1, operands are stored as magnitudes (|x|, WIDTH-bit unsigned; |-2^(WIDTH-1)| = 2^(WIDTH-1) is representable). neg = msb(mcand) XOR msb(mplier) is latched.
  - If sgn=0, operands are stored as-is and neg=0.
  - Product register: upper WIDTH+1 bits = 0 (carry-extended accumulator), lower WIDTH bits = multiplier magnitude. Counter = 0. Next state RUN.
- RUN: one iteration per cycle.
  - If product LSB = 1: accumulator += multiplicand (WIDTH+1-bit add, no overflow loss).
  - Then shift the combined register right by 1 with zero fill.
  - Counter increments. After WIDTH iterations, go to FIX.
- FIX (one cycle): if neg=1, product = two's-complement negation of the 2*WIDTH-bit magnitude; otherwise product = magnitude. Next state DONE.
- DONE (one cycle): done=1, busy=0. Next state IDLE. start is ignored in DONE.
- Latency: start accepted at edge N; done high during the cycle after edge N+WIDTH+2 (WIDTH+2 busy cycles, e.g. 34 for WIDTH=32).
- Product update rule: the product output updates only at the FIX->DONE edge. It holds the previous result through IDLE and RUN (internal working register is separate).
- start while busy or in DONE: ignored, with no effect on operands or the in-flight result.
- Operand inputs may change freely after the accepted start.
- Zero operand: follows the normal path (no early exit); latency is unchanged.
- Arithmetic: result is exact for all operand pairs in both modes. No overflow flag is needed, since 2*WIDTH bits always suffice.

Test Plan:
- Unsigned basic (WIDTH=32): reset, mcand=50, mplier=9832, signed_mode=0, start pulse -> busy for 34 cycles, then done pulse one cycle; product=491600 (0x0000_0000_0007_8050), holds afterwards.
- Signed: mcand=-3 (0xFFFF_FFFD), mplier=7, signed_mode=1 -> product=0xFFFF_FFFF_FFFF_FFEB (-21). Same operands with signed_mode=0 -> 0x0000_0006_FFFF_FFEB.
- Extremes: unsigned 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE_0000_0001. Signed 0x8000_0000 x 0x8000_0000 -> 0x4000_0000_0000_0000. Signed 0x8000_0000 x 1 -> 0xFFFF_FFFF_8000_0000.
- Handshake abuse: start=1 held continuously with operands changing every cycle -> only the first operands are used; start is ignored during busy and in DONE; next operation starts on the first IDLE cycle; each result is correct.
- Reset mid-op: assert rst=0 asynchronously (between edges) at iteration 10 -> busy, done and product go to 0 immediately; no done pulse; a fresh 50x9832 after release gives 491600.
- Parameter sweep: WIDTH=8, SIGNED_EN=0, mcand=0xFF, mplier=0x80, signed_mode=1 -> treated as unsigned, product=0x7F80, latency 10 cycles.
